// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_pkg
// Brief    : Shared types and constants for the adder sequencing AXI-Lite master.
// Revision : 1.0 - initial release
// ============================================================================
package adder_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_A = 3'd1,
        B_A  = 3'd2,
        WR_B = 3'd3,
        B_B  = 3'd4,
        AR   = 3'd5,
        R    = 3'd6,
        RSP  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        WP_IDLE = 2'd0,
        WP_ADDR = 2'd1,
        WP_RESP = 2'd2
    } wr_phase_t;

    localparam logic [7:0] c_reg_a_addr   = 8'h00;
    localparam logic [7:0] c_reg_b_addr   = 8'h04;
    localparam logic [7:0] c_reg_sum_addr = 8'h08;

    localparam logic c_resp_err = 1'b1;

    function automatic logic resp_is_err(input logic resp);
        return resp == c_resp_err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_seq_wr.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_wr
// Brief    : One AXI-Lite write: AW and W issued together, each completing on its
//            own handshake, followed by the B wait.
// Revision : 1.0 - initial release
// ============================================================================
module adder_seq_wr
    import adder_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_addr_done,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic                  i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready
);

    wr_phase_t             r_phase;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_aw_left;
    logic                  w_w_left;

    always_comb begin
        w_aw_left   = r_awvalid & ~i_awready;
        w_w_left    = r_wvalid & ~i_wready;
        o_addr_done = (r_phase == WP_ADDR) & ~w_aw_left & ~w_w_left;
        o_done      = r_bready & i_bvalid;
        o_err       = o_done & resp_is_err(i_bresp);
    end

    // A new start may coincide with the B handshake of the previous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= WP_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_phase)
                WP_ADDR: begin
                    r_awvalid <= w_aw_left;
                    r_wvalid  <= w_w_left;
                    if (!w_aw_left && !w_w_left) begin
                        r_bready <= 1'b1;
                        r_phase  <= WP_RESP;
                    end
                end
                WP_RESP: begin
                    if (i_bvalid) begin
                        r_bready <= 1'b0;
                        r_phase  <= WP_IDLE;
                    end
                end
                default: r_phase <= WP_IDLE;
            endcase
            if (i_start && r_phase != WP_ADDR) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= i_addr;
                r_wdata   <= i_data;
                r_phase   <= WP_ADDR;
            end
        end
    end

    assign o_awaddr  = r_awaddr;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;

endmodule
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_seq_ctrl
// Brief    : AXI4-Lite master that writes operands A and B to the adder slave,
//            reads back the sum and returns it on a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] REG_A_ADDR   = ADDR_WIDTH'(c_reg_a_addr),
    parameter logic [ADDR_WIDTH-1:0] REG_B_ADDR   = ADDR_WIDTH'(c_reg_b_addr),
    parameter logic [ADDR_WIDTH-1:0] REG_SUM_ADDR = ADDR_WIDTH'(c_reg_sum_addr)
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_areset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_sum,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
    output logic                    m1_axi_awvalid,
    input  logic                    m1_axi_awready,
    output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
    output logic                    m1_axi_wvalid,
    input  logic                    m1_axi_wready,
    input  logic                    m1_axi_bresp,
    input  logic                    m1_axi_bvalid,
    output logic                    m1_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
    output logic                    m1_axi_arvalid,
    input  logic                    m1_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
    input  logic                    m1_axi_rresp,
    input  logic                    m1_axi_rvalid,
    output logic                    m1_axi_rready
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_arvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_b;

    logic                  w_cmd_hs;
    logic                  w_rd_hs;
    logic                  w_rd_err;
    logic                  w_wr_start;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_wr_addr_done;
    logic                  w_wr_done;
    logic                  w_wr_err;

    assign w_cmd_hs = r_cmd_ready & cmd_valid;
    assign w_rd_hs  = r_rready & m1_axi_rvalid;
    assign w_rd_err = w_rd_hs & resp_is_err(m1_axi_rresp);

    always_comb begin
        w_next     = r_state;
        w_wr_start = 1'b0;
        w_wr_addr  = REG_A_ADDR;
        w_wr_data  = cmd_a;
        case (r_state)
            IDLE: if (w_cmd_hs) begin
                w_next     = WR_A;
                w_wr_start = 1'b1;
            end
            WR_A: if (w_wr_addr_done) w_next = B_A;
            B_A:  if (w_wr_done) begin
                w_next     = WR_B;
                w_wr_start = 1'b1;
                w_wr_addr  = REG_B_ADDR;
                w_wr_data  = r_b;
            end
            WR_B: if (w_wr_addr_done) w_next = B_B;
            B_B:  if (w_wr_done) w_next = AR;
            AR:   if (r_arvalid && m1_axi_arready) w_next = R;
            R:    if (w_rd_hs) w_next = RSP;
            RSP:  if (r_rsp_valid && rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each one is a plain flop.
    always_ff @(posedge m1_axi_aclk) begin
        if (m1_axi_areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_sum       <= '0;
            r_err       <= 1'b0;
            r_b         <= '0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == IDLE);
            r_busy      <= (w_next != IDLE);
            r_arvalid   <= (w_next == AR);
            r_rready    <= (w_next == R);
            r_rsp_valid <= (w_next == RSP);
            if (w_next == AR) r_araddr <= REG_SUM_ADDR;
            if (w_rd_hs) r_sum <= m1_axi_rdata;
            if (w_cmd_hs) begin
                r_b   <= cmd_b;
                r_err <= 1'b0;
            end else begin
                r_err <= r_err | w_wr_err | w_rd_err;
            end
        end
    end

    adder_seq_wr #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr (
        .clk         (m1_axi_aclk),
        .rst         (m1_axi_areset),
        .i_start     (w_wr_start),
        .i_addr      (w_wr_addr),
        .i_data      (w_wr_data),
        .o_addr_done (w_wr_addr_done),
        .o_done      (w_wr_done),
        .o_err       (w_wr_err),
        .o_awaddr    (m1_axi_awaddr),
        .o_awvalid   (m1_axi_awvalid),
        .i_awready   (m1_axi_awready),
        .o_wdata     (m1_axi_wdata),
        .o_wvalid    (m1_axi_wvalid),
        .i_wready    (m1_axi_wready),
        .i_bresp     (m1_axi_bresp),
        .i_bvalid    (m1_axi_bvalid),
        .o_bready    (m1_axi_bready)
    );

    assign cmd_ready      = r_cmd_ready;
    assign busy           = r_busy;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_sum        = r_sum;
    assign rsp_err        = r_err;
    assign m1_axi_wstrb   = '1;
    assign m1_axi_araddr  = r_araddr;
    assign m1_axi_arvalid = r_arvalid;
    assign m1_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_seq_ctrl
// Brief    : Self-checking bench for adder_seq_ctrl with a behavioural adder slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] cmd_a, cmd_b, rsp_sum;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bresp, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        arvalid, arready, rresp, rvalid, rready;

    adder_seq_ctrl dut (
        .m1_axi_aclk    (clk),
        .m1_axi_areset  (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_sum        (rsp_sum),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .m1_axi_awaddr  (awaddr),
        .m1_axi_awvalid (awvalid),
        .m1_axi_awready (awready),
        .m1_axi_wdata   (wdata),
        .m1_axi_wstrb   (wstrb),
        .m1_axi_wvalid  (wvalid),
        .m1_axi_wready  (wready),
        .m1_axi_bresp   (bresp),
        .m1_axi_bvalid  (bvalid),
        .m1_axi_bready  (bready),
        .m1_axi_araddr  (araddr),
        .m1_axi_arvalid (arvalid),
        .m1_axi_arready (arready),
        .m1_axi_rdata   (rdata),
        .m1_axi_rresp   (rresp),
        .m1_axi_rvalid  (rvalid),
        .m1_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural adder slave with per-channel wait states and error injection
    int aw_dly_a = 0, aw_dly_b = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic berr_a = 0, berr_b = 0, rerr = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, b_pend, r_pend;
    logic [7:0]  s_awaddr;
    logic [31:0] s_wdata, reg_a, reg_b;
    logic [7:0]  wr_q[$];
    logic [7:0]  rd_q[$];

    assign awready = awvalid && !aw_got && (aw_cnt >= ((awaddr == 8'h04) ? aw_dly_b : aw_dly_a));
    assign wready  = wvalid && !w_got && (w_cnt >= w_dly);
    assign bvalid  = b_pend && (b_cnt >= b_dly);
    assign bresp   = (s_awaddr == 8'h04) ? berr_b : berr_a;
    assign arready = arvalid && !r_pend && (ar_cnt >= ar_dly);
    assign rvalid  = r_pend && (r_cnt >= r_dly);
    assign rdata   = reg_a + reg_b;
    assign rresp   = rerr;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
            s_awaddr <= 0; s_wdata <= 0; reg_a <= 0; reg_b <= 0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1; s_awaddr <= awaddr; aw_cnt <= 0; wr_q.push_back(awaddr);
            end else if (awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                w_got <= 1; s_wdata <= wdata; w_cnt <= 0;
            end else if (wvalid && !w_got) w_cnt <= w_cnt + 1;
            if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)) && !b_pend) begin
                b_pend <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0;
                if ((aw_got ? s_awaddr : awaddr) == 8'h00) reg_a <= w_got ? s_wdata : wdata;
                if ((aw_got ? s_awaddr : awaddr) == 8'h04) reg_b <= w_got ? s_wdata : wdata;
            end
            if (b_pend) begin
                if (bvalid && bready) b_pend <= 0; else b_cnt <= b_cnt + 1;
            end
            if (arvalid && arready) begin
                r_pend <= 1; r_cnt <= 0; ar_cnt <= 0; rd_q.push_back(araddr);
            end else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (r_pend) begin
                if (rvalid && rready) r_pend <= 0; else r_cnt <= r_cnt + 1;
            end
        end
    end

    // AXI valid/stability monitor, evaluated between edges
    logic rst_q = 1'b1;
    logic pv_awv = 0, pv_awr = 0, pv_wv = 0, pv_wr = 0, pv_arv = 0, pv_arr = 0;
    logic [7:0]  pv_awaddr = 0, pv_araddr = 0;
    logic [31:0] pv_wdata = 0;

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (!rst_q && pv_awv && !pv_awr) check("aw_hold", {awvalid, awaddr}, {1'b1, pv_awaddr});
        if (!rst_q && pv_awv && pv_awr)  check("aw_drop", awvalid, 0);
        if (!rst_q && pv_wv && !pv_wr)   check("w_hold", {wvalid, wdata}, {1'b1, pv_wdata});
        if (!rst_q && pv_wv && pv_wr)    check("w_drop", wvalid, 0);
        if (!rst_q && pv_arv && !pv_arr) check("ar_hold", {arvalid, araddr}, {1'b1, pv_araddr});
        pv_awv = awvalid; pv_awr = awready; pv_awaddr = awaddr;
        pv_wv = wvalid; pv_wr = wready; pv_wdata = wdata;
        pv_arv = arvalid; pv_arr = arready; pv_araddr = araddr;
    end

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Zero-wait latency is 7; every slave wait state adds one cycle.
    function automatic int exp_latency();
        return 7 + imax(aw_dly_a, w_dly) + b_dly + imax(aw_dly_b, w_dly) + b_dly + ar_dly + r_dly;
    endfunction

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_sum, input logic exp_err,
                          input int hold, input int exp_lat);
        int n;
        logic [31:0] s;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        wr_q.delete();
        rd_q.delete();
        rsp_ready = (hold == 0);
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        check({tag, "_busy"}, {busy, cmd_ready}, 2'b10);
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_sum"}, rsp_sum, exp_sum);
        check({tag, "_err"}, rsp_err, exp_err);
        s = rsp_sum;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {rsp_valid, rsp_sum, cmd_ready, awvalid, wvalid, arvalid, bready, rready},
                  {1'b1, s, 6'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_after_rsp"}, {rsp_valid, cmd_ready}, 2'b01);
        check({tag, "_addrs"},
              {(wr_q.size() == 2) ? {wr_q[0], wr_q[1]} : 16'hxxxx, (rd_q.size() == 1) ? rd_q[0] : 8'hxx},
              24'h000408);
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {cmd_ready, busy, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}, 0);
        check("reset_data", {rsp_sum, awaddr, araddr, wdata}, 0);
        check("reset_wstrb", wstrb, 4'hF);
        rst = 1'b0;
        @(negedge clk);

        run_op("zero_wait", 32'h0000AABB, 32'h0000CCDD, 32'h00017798, 1'b0, 0, 7);

        aw_dly_a = 3;
        run_op("aw_delay", 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 0, 10);
        aw_dly_a = 0;

        berr_b = 1;
        run_op("bresp_b", 32'd100, 32'd200, 32'd300, 1'b1, 0, 7);
        berr_b = 0;
        run_op("clean", 32'd9, 32'd10, 32'd19, 1'b0, 0, 7);

        run_op("rsp_stall", 32'hDEAD0000, 32'h0000BEEF, 32'hDEADBEEF, 1'b0, 5, 7);

        // Reset while the read address is outstanding
        ar_dly = 2;
        cmd_a = 32'hAAAA0000; cmd_b = 32'h00005555; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!arvalid && n < 50) begin @(negedge clk); n++; end
        check("rst_reached_ar", arvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_op", {arvalid, busy, rready, bready, awvalid, wvalid, rsp_valid, cmd_ready}, 0);
        rst = 1'b0;
        ar_dly = 0;
        @(negedge clk);
        run_op("after_rst", 32'd1, 32'd2, 32'd3, 1'b0, 0, 7);

        run_op("b2b_wrap", 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b0, 0, 7);
        run_op("b2b_second", 32'd5, 32'd7, 32'h0000000C, 1'b0, 0, 7);

        for (int k = 0; k < 20; k++) begin
            aw_dly_a = $urandom_range(0, 3);
            aw_dly_b = $urandom_range(0, 3);
            w_dly    = $urandom_range(0, 3);
            b_dly    = $urandom_range(0, 2);
            ar_dly   = $urandom_range(0, 2);
            r_dly    = $urandom_range(0, 2);
            berr_a   = ($urandom_range(0, 3) == 0);
            berr_b   = ($urandom_range(0, 3) == 0);
            rerr     = ($urandom_range(0, 3) == 0);
            a = $urandom();
            b = $urandom();
            run_op($sformatf("rand%0d", k), a, b, a + b, berr_a | berr_b | rerr,
                   $urandom_range(0, 2), exp_latency());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
